// File: rtl/char_assembler_if.sv
// Receive-path character bus: serial bit strobes in, assembled characters out.
// The assembler sits on the slave side; whoever supplies bits and consumes
// characters (bit sample counter / downstream logic) uses the master side.
// CHAR_W here must match the CHAR_W of the attached char_assembler.
interface char_assembler_if #(
  parameter int CHAR_W = 8
) ();
  logic              dataIn;
  logic              bitValid;
  logic [CHAR_W-1:0] charOut;
  logic              charValid;
  logic              frameErr;
  logic              busy;
  logic [3:0]        bitCount;

  modport master (
    output dataIn,
    output bitValid,
    input  charOut,
    input  charValid,
    input  frameErr,
    input  busy,
    input  bitCount
  );

  modport slave (
    input  dataIn,
    input  bitValid,
    output charOut,
    output charValid,
    output frameErr,
    output busy,
    output bitCount
  );
endinterface

// File: rtl/char_assembler.sv
// Serial-to-parallel character assembler. Frames start / DATA_BITS data bits
// (LSB first) / stop bit from a per-bit strobe, presents the character with a
// one-cycle valid pulse, flags bad stop bits, and reports busy for the whole
// character so the upstream sampler can hold its window.
module char_assembler #(
  parameter int DATA_BITS = 8,  // 5..8
  parameter int CHAR_W    = 8   // must be >= DATA_BITS
) (
  input logic            clk,
  input logic            rst,
  char_assembler_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_t;

  localparam logic [3:0] LAST_COUNT = 4'(DATA_BITS - 1);
  localparam logic [3:0] FULL_COUNT = 4'(DATA_BITS);

  state_t               state_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic [CHAR_W-1:0]    char_out_reg;
  logic                 char_valid_reg;
  logic                 frame_err_reg;
  logic                 busy_reg;
  logic [3:0]           bit_count_reg;

  // Shift register zero-extended to the output width; bits above DATA_BITS are 0.
  logic [CHAR_W-1:0]    shift_ext;

  generate
    for (genvar gi = 0; gi < CHAR_W; gi++) begin : g_ext
      if (gi < DATA_BITS) begin : g_data
        assign shift_ext[gi] = shift_reg[gi];
      end else begin : g_zero
        assign shift_ext[gi] = 1'b0;
      end
    end
  endgenerate

  // Framing FSM with registered outputs; state only advances on bit strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      shift_reg      <= '0;
      char_out_reg   <= '0;
      char_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      busy_reg       <= 1'b0;
      bit_count_reg  <= 4'd0;
    end else begin
      char_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      if (bus.bitValid) begin
        case (state_reg)
          IDLE: begin
            // A high bit in IDLE is line idle or a false start: ignore it.
            if (!bus.dataIn) begin
              state_reg     <= DATA;
              busy_reg      <= 1'b1;
              bit_count_reg <= 4'd0;
              shift_reg     <= '0;
            end
          end
          DATA: begin
            // LSB arrives first, so new bits enter at the top and walk down.
            shift_reg <= {bus.dataIn, shift_reg[DATA_BITS-1:1]};
            if (bit_count_reg != FULL_COUNT) begin
              bit_count_reg <= bit_count_reg + 4'd1;
            end
            if (bit_count_reg == LAST_COUNT) begin
              state_reg <= STOP;
            end
          end
          STOP: begin
            if (bus.dataIn) begin
              char_out_reg   <= shift_ext;
              char_valid_reg <= 1'b1;
            end else begin
              // Bad stop bit (or break): report it, keep the last good character.
              frame_err_reg  <= 1'b1;
            end
            state_reg     <= IDLE;
            busy_reg      <= 1'b0;
            bit_count_reg <= 4'd0;
          end
          default: begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.charOut   = char_out_reg;
  assign bus.charValid = char_valid_reg;
  assign bus.frameErr  = frame_err_reg;
  assign bus.busy      = busy_reg;
  assign bus.bitCount  = bit_count_reg;

endmodule

// File: tb/tb_char_assembler.sv
// Bench for char_assembler: an 8-bit and a 7-bit instance share one bit
// stream and are both compared every cycle against a frame-level model.
module tb_char_assembler;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic din = 1'b1;
  logic bv  = 1'b0;

  always #5 clk = ~clk;

  char_assembler_if #(.CHAR_W(8)) bus8 ();
  char_assembler_if #(.CHAR_W(8)) bus7 ();

  assign bus8.dataIn   = din;
  assign bus8.bitValid = bv;
  assign bus7.dataIn   = din;
  assign bus7.bitValid = bv;

  char_assembler #(.DATA_BITS(8), .CHAR_W(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8.slave)
  );

  char_assembler #(.DATA_BITS(7), .CHAR_W(8)) dut7 (
    .clk (clk),
    .rst (rst),
    .bus (bus7.slave)
  );

  int checks   = 0;
  int failures = 0;

  // Frame-level model: pos = -1 when waiting for a start bit, otherwise the
  // number of data bits collected so far (== data bits means stop expected).
  int db [2] = '{8, 7};
  int pos [2];
  int acc [2];
  int m_out [2];
  bit m_valid [2];
  bit m_err [2];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        pos[k] = -1; acc[k] = 0; m_out[k] = 0; m_valid[k] = 0; m_err[k] = 0;
      end else begin
        m_valid[k] = 0;
        m_err[k]   = 0;
        if (bv) begin
          if (pos[k] < 0) begin
            if (!din) begin
              pos[k] = 0;
              acc[k] = 0;
            end
          end else if (pos[k] < db[k]) begin
            acc[k] = acc[k] + ((din ? 1 : 0) << pos[k]);
            pos[k] = pos[k] + 1;
          end else begin
            if (din) begin
              m_out[k]   = acc[k];
              m_valid[k] = 1;
            end else begin
              m_err[k] = 1;
            end
            pos[k] = -1;
          end
        end
      end
    end
  endtask

  task automatic check_outputs();
    check_eq("d8.charOut",   32'(bus8.charOut),   32'(m_out[0]));
    check_eq("d8.charValid", 32'(bus8.charValid), 32'(m_valid[0]));
    check_eq("d8.frameErr",  32'(bus8.frameErr),  32'(m_err[0]));
    check_eq("d8.busy",      32'(bus8.busy),      32'(pos[0] >= 0));
    check_eq("d8.bitCount",  32'(bus8.bitCount),  32'(pos[0] < 0 ? 0 : pos[0]));
    check_eq("d7.charOut",   32'(bus7.charOut),   32'(m_out[1]));
    check_eq("d7.charValid", 32'(bus7.charValid), 32'(m_valid[1]));
    check_eq("d7.frameErr",  32'(bus7.frameErr),  32'(m_err[1]));
    check_eq("d7.busy",      32'(bus7.busy),      32'(pos[1] >= 0));
    check_eq("d7.bitCount",  32'(bus7.bitCount),  32'(pos[1] < 0 ? 0 : pos[1]));
  endtask

  // One clock: apply inputs, let the edge happen, then compare #1 later.
  task automatic step(input bit r, input bit v, input bit d);
    rst = r;
    bv  = v;
    din = d;
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic send_bit(input bit d, input int gap);
    step(1'b0, 1'b1, d);
    for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'($urandom));
  endtask

  task automatic send_frame(input int value, input int nbits, input bit stop, input int gap);
    send_bit(1'b0, gap);
    for (int i = 0; i < nbits; i++) send_bit(value[i], gap);
    send_bit(stop, gap);
    $display("frame value=%02h bits=%0d stop=%0d out8=%02h out7=%02h",
             value, nbits, stop, bus8.charOut, bus7.charOut);
  endtask

  initial begin
    // Reset sequence.
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0);   // reset beats a simultaneous strobe
    step(1'b0, 1'b0, 1'b1);
    check_eq("rst.charOut", 32'(bus8.charOut), 32'h0);
    check_eq("rst.busy",    32'(bus8.busy),    32'h0);

    // 0x55 with 15 idle cycles between strobes.
    send_frame(32'h55, 8, 1'b1, 15);
    check_eq("frame_55", 32'(bus8.charOut), 32'h55);

    // 0xA3 with a bad stop bit: error pulse, character kept.
    send_frame(32'hA3, 8, 1'b0, 2);
    check_eq("keep_55", 32'(bus8.charOut), 32'h55);

    // Back-to-back 0x41 / 0x7E, strobes on consecutive cycles.
    send_frame(32'h41, 8, 1'b1, 0);
    send_frame(32'h7E, 8, 1'b1, 0);
    check_eq("frame_7e", 32'(bus8.charOut), 32'h7E);

    // Line idle: high strobes in IDLE are ignored.
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1);
    check_eq("idle_busy", 32'(bus8.busy), 32'h0);

    // Reset after 4 data bits, then a clean 0x3C.
    send_bit(1'b0, 1);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1);
    step(1'b1, 1'b0, 1'b0);
    check_eq("midrst_busy",  32'(bus8.busy),     32'h0);
    check_eq("midrst_count", 32'(bus8.bitCount), 32'h0);
    send_frame(32'h3C, 8, 1'b1, 1);
    check_eq("frame_3c", 32'(bus8.charOut), 32'h3C);

    // 7-bit character on the 7-bit instance.
    step(1'b1, 1'b0, 1'b1);
    send_frame(32'h5A, 7, 1'b1, 2);
    check_eq("frame7_5a", 32'(bus7.charOut), 32'h5A);

    // Break: all zeros.
    step(1'b1, 1'b0, 1'b1);
    send_frame(32'h00, 8, 1'b0, 0);

    // Randomized frames, noise and occasional resets.
    for (int n = 0; n < 80; n++) begin
      int nb;
      if ($urandom_range(9) == 0) step(1'b1, 1'b0, 1'($urandom));
      for (int j = 0; j < int'($urandom_range(3)); j++) step(1'b0, 1'($urandom), 1'($urandom));
      nb = ($urandom_range(1) == 0) ? 7 : 8;
      send_frame(int'($urandom_range(255)), nb, $urandom_range(7) != 0, int'($urandom_range(2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/char_assembler.md
Name: char_assembler

Overview:
- Serial-to-parallel stage directly downstream of the bit sample counter in the receive path.
- Consumes one mid-bit sample plus a one-cycle bit strobe per bit time, frames start / data / stop bits, and presents an assembled character with a one-cycle valid pulse.
- Flags framing errors and reports busy so the upstream counter can hold its sampling window across a whole character.

Parameters:
- DATA_BITS, default 8: data bits per character. Legal range 5..8.
- CHAR_W, default 8: width of charOut. Unused upper bits are driven 0.

Ports:
- clk, input, 1: system clock; all state updates on rising edge.
- rst, input, 1: synchronous, active-high reset.
- dataIn, input, 1: sampled serial bit from the bit sample counter; meaningful only when bitValid=1.
- bitValid, input, 1: one-cycle strobe, one per received bit time; each high cycle counts as one bit.
- charOut, output, CHAR_W: last correctly framed character, LSB = first data bit received.
- charValid, output, 1: one-cycle pulse; charOut is new this cycle.
- frameErr, output, 1: one-cycle pulse; stop bit sampled as 0.
- busy, output, 1: high from accepted start bit until the stop bit is consumed.
- bitCount, output, 4: data bits received in the current character (debug/verification).

Behaviour:
- Clock and reset:
  - One clock: clk. Reset rst is synchronous and active-high; it has priority over every other input, including bitValid in the same cycle.
  - Reset values: charOut=0, charValid=0, frameErr=0, busy=0, bitCount=0, internal shift register=0, state=IDLE.
- States: IDLE, DATA, STOP (2-bit encoded). Nothing changes on cycles with bitValid=0, except that charValid and frameErr clear.
- IDLE:
  - bitValid & dataIn=0: start bit accepted. Go to DATA; busy=1 from the next cycle; bitCount=0; shift register cleared.
  - bitValid & dataIn=1: false start or line idle. Ignored; stay in IDLE.
- DATA:
  - On each bitValid: shift register shifts right and dataIn enters bit DATA_BITS-1; bitCount increments.
  - On the strobe that makes bitCount reach DATA_BITS: go to STOP.
  - bitCount saturates at DATA_BITS and never wraps.
- STOP, on bitValid:
  - dataIn=1: charOut takes the shift register value, zero-extended to CHAR_W. charValid=1 for exactly the next cycle. Go to IDLE; busy=0; bitCount=0.
  - dataIn=0: frameErr=1 for exactly the next cycle; charOut unchanged; charValid stays 0. Go to IDLE; busy=0.
  - A break (all zeros) therefore yields a single frameErr pulse and no character.
- Latency: charValid / frameErr rise on the clock edge that samples the stop bit (registered outputs, visible the following cycle).
- Back-to-back characters: a bitValid with dataIn=0 on the cycle after the stop strobe is accepted as the next start bit. There is no idle gap requirement.
- Consecutive bitValid cycles are legal; each one is a separate bit.
- charValid and frameErr are never high in the same cycle.
- charOut holds its value until the next good character or reset.
- Reset mid-character discards the partial character; no charValid or frameErr pulse is generated.

Test Plan:
- Reset sequence: rst=1 for 2 cycles, then rst=0 -> all outputs 0, busy=0, state IDLE.
- Frame 0 (start), then 1,0,1,0,1,0,1,0 (LSB first), then 1 (stop), strobed every 16 cycles -> charOut=8'h55 and charValid high exactly one cycle after the stop strobe; busy high from start until stop.
- Frame start, 8 data bits of 0xA3 LSB first, stop=0 -> frameErr one-cycle pulse, charValid never high, charOut keeps previous 8'h55.
- Two frames 0x41 then 0x7E with the next start strobe on the cycle after the first stop strobe -> two charValid pulses, charOut=8'h41 then 8'h7E.
- In IDLE, bitValid with dataIn=1 for 5 strobes -> busy stays 0, no pulses.
- rst asserted after 4 data bits of a frame -> next cycle busy=0, bitCount=0, no charValid or frameErr. A following full frame of 0x3C is received correctly.
- DATA_BITS=7, frame 0x5A truncated to 7 bits -> charOut=8'h5A.
